// File: rtl/io_bank_pkg.sv
// Shared types and address-decode helpers for the Wishbone I/O register bank.
package io_bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAITS,
        ACK
    } state_t;

    localparam logic [15:0] UNMAPPED_WORD = 16'hFFFF;

    // A 16-bit wrap below base yields a huge offset and so falls out of range.
    function automatic logic in_range(input logic [15:0] adr,
                                      input logic [15:0] base,
                                      input int unsigned nregs);
        logic [15:0] off;
        off = adr - base;
        return {16'h0000, off} < (2 * nregs);
    endfunction

    function automatic logic [15:0] reg_index(input logic [15:0] adr,
                                              input logic [15:0] base);
        logic [15:0] off;
        off = adr - base;
        return off >> 1;
    endfunction

endpackage

// File: rtl/io_reg_word.sv
// One 16-bit register with independent byte-lane write enables and a reset value.
module io_reg_word #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [7:0]  d_lo,
    input  logic [7:0]  d_hi,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            if (we_lo) q[7:0]  <= d_lo;
            if (we_hi) q[15:8] <= d_hi;
        end
    end

endmodule

// File: rtl/io_reg_bank.sv
// Parametrised Wishbone I/O register bank: NREGS byte-addressable 16-bit
// registers with wait-state ack handshake and optional unmapped-port response.
module io_reg_bank
    import io_bank_pkg::*;
#(
    parameter int unsigned NREGS        = 4,
    parameter logic [15:0] BASE         = 16'h00B6,
    parameter int unsigned WAIT         = 0,
    parameter bit          ACK_UNMAPPED = 1'b1,
    parameter logic [15:0] RESET_VAL    = 16'h0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           adr_i,
    input  logic [15:0]           dat_i,
    output logic [15:0]           dat_o,
    input  logic                  we_i,
    input  logic                  byte_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    output logic [16*NREGS-1:0]   regs_o
);

    state_t            state, state_nx;
    logic              mapped, claimed, cnt_zero, enter_ack;
    logic [15:0]       k;
    logic [15:0]       sel, rd_val;
    logic [NREGS-1:0]  we_lo_d, we_hi_d, we_lo_q, we_hi_q;
    logic [7:0]        d_hi_d, d_lo_q, d_hi_q;
    logic [15:0]       regq [NREGS];

    assign mapped  = in_range(adr_i, BASE, NREGS);
    assign claimed = mapped || ACK_UNMAPPED;
    assign k       = reg_index(adr_i, BASE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (stb_i && claimed) state_nx = (WAIT == 0) ? ACK : WAITS;
            WAITS:   if (!stb_i) state_nx = IDLE;
                     else if (cnt_zero) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ACK never persists, so a next state of ACK always marks entry into it.
    assign enter_ack = (state_nx == ACK);

    generate
        if (WAIT > 0) begin : g_wait
            logic [3:0] cnt;
            always_ff @(posedge clk_i) begin
                if (rst_i)                          cnt <= '0;
                else if (state == IDLE)             cnt <= 4'(WAIT - 1);
                else if (state == WAITS && cnt != 0) cnt <= cnt - 4'd1;
            end
            assign cnt_zero = (cnt == '0);
        end else begin : g_nowait
            assign cnt_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        sel     = '0;
        we_lo_d = '0;
        we_hi_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (k == 16'(i)) sel = regq[i];
            if (mapped && we_i && k == 16'(i)) begin
                we_lo_d[i] = !adr_i[0];
                we_hi_d[i] = byte_i ? adr_i[0] : !adr_i[0];
            end
        end
        d_hi_d = byte_i ? dat_i[7:0] : dat_i[15:8];

        rd_val = '0;
        if (we_i)           rd_val = '0;
        else if (!mapped)   rd_val = byte_i ? 16'h00FF : UNMAPPED_WORD;
        else if (byte_i)    rd_val = {8'h00, adr_i[0] ? sel[15:8] : sel[7:0]};
        else if (!adr_i[0]) rd_val = sel;
    end

    // Write intent is captured on ACK entry and applied at the end of ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ack_o   <= 1'b0;
            dat_o   <= '0;
            we_lo_q <= '0;
            we_hi_q <= '0;
            d_lo_q  <= '0;
            d_hi_q  <= '0;
        end else begin
            state   <= state_nx;
            ack_o   <= enter_ack;
            dat_o   <= enter_ack ? rd_val  : '0;
            we_lo_q <= enter_ack ? we_lo_d : '0;
            we_hi_q <= enter_ack ? we_hi_d : '0;
            if (enter_ack) begin
                d_lo_q <= dat_i[7:0];
                d_hi_q <= d_hi_d;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            io_reg_word #(.RESET_VAL(RESET_VAL)) u_word (
                .clk   (clk_i),
                .rst   (rst_i),
                .we_lo (we_lo_q[gi]),
                .we_hi (we_hi_q[gi]),
                .d_lo  (d_lo_q),
                .d_hi  (d_hi_q),
                .q     (regq[gi])
            );
            assign regs_o[16*gi +: 16] = regq[gi];
        end
    endgenerate

endmodule

// File: tb/tb_io_reg_bank.sv
// Directed self-checking bench for io_reg_bank across three parameter sets.
module tb_io_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr, dat;
    logic        we, byt;
    logic        stb_a, stb_b, stb_c;
    logic        ack_a, ack_b, ack_c;
    logic [15:0] dat_a, dat_b, dat_c;
    logic [63:0] regs_a, regs_b, regs_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_reg_bank #(.NREGS(4), .BASE(16'h00B6), .WAIT(0), .ACK_UNMAPPED(1'b1), .RESET_VAL(16'h0000)) dut_a (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .dat_o(dat_a), .we_i(we),
        .byte_i(byt), .stb_i(stb_a), .ack_o(ack_a), .regs_o(regs_a));

    io_reg_bank #(.NREGS(4), .BASE(16'h00B6), .WAIT(3), .ACK_UNMAPPED(1'b1), .RESET_VAL(16'hC3C3)) dut_b (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .dat_o(dat_b), .we_i(we),
        .byte_i(byt), .stb_i(stb_b), .ack_o(ack_b), .regs_o(regs_b));

    io_reg_bank #(.NREGS(4), .BASE(16'h00B6), .WAIT(0), .ACK_UNMAPPED(1'b0), .RESET_VAL(16'h0000)) dut_c (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .dat_o(dat_c), .we_i(we),
        .byte_i(byt), .stb_i(stb_c), .ack_o(ack_c), .regs_o(regs_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 0) ? ack_a : (sel == 1) ? ack_b : ack_c;
    endfunction

    function automatic logic [15:0] dat_of(input int sel);
        return (sel == 0) ? dat_a : (sel == 1) ? dat_b : dat_c;
    endfunction

    // lat = edges from first sampled stb to ack (0 if none); ack_after = ack one cycle later.
    task automatic bus(input int sel, input logic [15:0] a, input logic w, input logic b,
                       input logic [15:0] d, input int maxc,
                       output int lat, output logic [15:0] rd, output logic ack_after);
        lat = 0;
        rd = '0;
        @(posedge clk); #1;
        adr = a; we = w; byt = b; dat = d;
        stb_a = (sel == 0); stb_b = (sel == 1); stb_c = (sel == 2);
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            if (ack_of(sel)) begin
                lat = n;
                rd = dat_of(sel);
                break;
            end
        end
        @(posedge clk); #1;
        ack_after = ack_of(sel);
        stb_a = 0; stb_b = 0; stb_c = 0; we = 0;
    endtask

    int          lat;
    logic [15:0] rd;
    logic        aa;
    int          nack;
    logic        seen;

    initial begin
        rst = 1; adr = '0; dat = '0; we = 0; byt = 0;
        stb_a = 0; stb_b = 0; stb_c = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(ack_a), 64'h0);
        check("rst_dat", 64'(dat_a), 64'h0);
        check("rst_regs_a", regs_a, 64'h0);
        check("rst_regs_b", regs_b, 64'hC3C3_C3C3_C3C3_C3C3);
        rst = 0;

        bus(0, 16'h00B6, 1, 0, 16'h1234, 20, lat, rd, aa);
        check("w1234_lat", 64'(lat), 64'd1);
        check("w1234_width", 64'(aa), 64'h0);
        check("w1234_regs", regs_a, 64'h0000_0000_0000_1234);
        bus(0, 16'h00B6, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("r1234_lat", 64'(lat), 64'd1);
        check("r1234_dat", 64'(rd), 64'h1234);

        bus(0, 16'h00B7, 1, 1, 16'h55AB, 20, lat, rd, aa);
        check("wbyte_regs", regs_a, 64'h0000_0000_0000_AB34);
        bus(0, 16'h00B7, 0, 1, 16'h0000, 20, lat, rd, aa);
        check("rbyte_hi", 64'(rd), 64'h00AB);
        bus(0, 16'h00B6, 0, 1, 16'h0000, 20, lat, rd, aa);
        check("rbyte_lo", 64'(rd), 64'h0034);
        bus(0, 16'h00B6, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("rword_ab34", 64'(rd), 64'hAB34);

        bus(1, 16'h00BC, 1, 0, 16'h5A5A, 20, lat, rd, aa);
        check("wait3_lat", 64'(lat), 64'd4);
        check("wait3_width", 64'(aa), 64'h0);
        check("wait3_regs", regs_b, 64'h5A5A_C3C3_C3C3_C3C3);

        bus(0, 16'h0060, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("unm_lat", 64'(lat), 64'd1);
        check("unm_word", 64'(rd), 64'hFFFF);
        bus(0, 16'h0060, 0, 1, 16'h0000, 20, lat, rd, aa);
        check("unm_byte", 64'(rd), 64'h00FF);
        bus(0, 16'h00BE, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("unm_above", 64'(rd), 64'hFFFF);
        bus(0, 16'h00B5, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("unm_below", 64'(rd), 64'hFFFF);
        bus(0, 16'h0060, 1, 0, 16'h9999, 20, lat, rd, aa);
        check("unm_wr_ack", 64'(lat), 64'd1);
        check("unm_wr_regs", regs_a, 64'h0000_0000_0000_AB34);
        bus(2, 16'h0060, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("silent_noack", 64'(lat), 64'd0);
        bus(2, 16'h00B8, 1, 0, 16'h0F0F, 20, lat, rd, aa);
        check("silent_mapped_lat", 64'(lat), 64'd1);
        check("silent_mapped_regs", regs_c, 64'h0000_0000_0F0F_0000);

        bus(0, 16'h00B9, 1, 0, 16'hFFFF, 20, lat, rd, aa);
        check("misal_ack", 64'(lat), 64'd1);
        check("misal_regs", regs_a, 64'h0000_0000_0000_AB34);
        bus(0, 16'h00B9, 0, 0, 16'h0000, 20, lat, rd, aa);
        check("misal_rd", 64'(rd), 64'h0000);
        bus(0, 16'h00BD, 1, 1, 16'h0077, 20, lat, rd, aa);
        check("last_port_regs", regs_a, 64'h7700_0000_0000_AB34);

        // abort: strobe dropped while waiting
        @(posedge clk); #1;
        adr = 16'h00B8; dat = 16'h2222; we = 1; byt = 0; stb_b = 1;
        @(posedge clk); #1;
        stb_b = 0;
        nack = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack_b) nack++;
        end
        check("abort_noack", 64'(nack), 64'd0);
        check("abort_regs", regs_b, 64'h5A5A_C3C3_C3C3_C3C3);

        // reset asserted during the ACK cycle of a write
        adr = 16'h00B6; dat = 16'h1111; we = 1; byt = 0; stb_b = 1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ack_b) begin
                seen = 1;
                break;
            end
        end
        check("rst_in_ack_seen", 64'(seen), 64'h1);
        rst = 1;
        @(posedge clk); #1;
        check("rst_in_ack_ack", 64'(ack_b), 64'h0);
        check("rst_in_ack_regs", regs_b, 64'hC3C3_C3C3_C3C3_C3C3);
        stb_b = 0; we = 0; rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ack_after", regs_b, 64'hC3C3_C3C3_C3C3_C3C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
